// File: rtl/instr_loader.sv
// instr_loader
//   Fills the instruction memory from a framed byte stream and holds the
//   pipeline while doing so.
//   Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes (words MSB first),
//   CHK = XOR of all data bytes.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   START               begin a load (honoured in IDLE / FIN_OK / FIN_ERR)
//   BYTE_VALID/DATA     byte source, transfers when BYTE_READY is also high
//   BYTE_READY          registered, high in every loading state
//   WR_EN/ADDRESS/DATA  one-cycle word write strobe with held address/data
//   CPU_HOLD            pipeline hold while loading
//   DONE / ERROR        sticky completion / failure status
module instr_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        START,
   input  logic        BYTE_VALID,
   input  logic [7:0]  BYTE_DATA,
   output logic        BYTE_READY,
   output logic        WR_EN,
   output logic [31:0] WR_ADDRESS,
   output logic [31:0] WR_DATA,
   output logic        CPU_HOLD,
   output logic        DONE,
   output logic        ERROR
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_FIN_OK, S_FIN_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   widx_q, widx_d;
   logic [1:0]    bidx_q, bidx_d;
   logic [23:0]   word_q, word_d;    // first three bytes of the word in flight
   logic [7:0]    acc_q, acc_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          rdy_q, rdy_d;
   logic          wr_en_q, wr_en_d;
   logic [31:0]   wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          accept;
   logic [15:0]   n_len;

   function automatic logic loading(input state_t s);
      return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CHECK);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         widx_q    <= '0;
         bidx_q    <= '0;
         word_q    <= '0;
         acc_q     <= '0;
         tmo_q     <= '0;
         rdy_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= BASE_ADDR;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         widx_q    <= widx_d;
         bidx_q    <= bidx_d;
         word_q    <= word_d;
         acc_q     <= acc_d;
         tmo_q     <= tmo_d;
         rdy_q     <= rdy_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      widx_d    = widx_q;
      bidx_d    = bidx_q;
      word_d    = word_q;
      acc_d     = acc_q;
      tmo_d     = tmo_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      accept    = BYTE_VALID && rdy_q;
      n_len     = {len_q[15:8], BYTE_DATA};

      case (state_q)
         S_IDLE, S_FIN_OK, S_FIN_ERR: begin
            if (START) begin
               state_d = S_LEN_HI;
               widx_d  = '0;
               bidx_d  = '0;
               acc_d   = '0;
               tmo_d   = '0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d   = {BYTE_DATA, 8'h00};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d = n_len;
               if (n_len == 16'd0)                state_d = S_CHECK;
               else if (32'(n_len) > MAX_WORDS)   state_d = S_FIN_ERR;
               else                               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d = {word_q[15:0], BYTE_DATA};
               acc_d  = acc_q ^ BYTE_DATA;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  // address wraps modulo 2^32 by construction
                  wr_en_d   = 1'b1;
                  wr_addr_d = BASE_ADDR + {14'b0, widx_q, 2'b00};
                  wr_data_d = {word_q, BYTE_DATA};
                  widx_d    = widx_q + 16'd1;
                  if (widx_q == len_q - 16'd1) state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (accept) state_d = (BYTE_DATA == acc_q) ? S_FIN_OK : S_FIN_ERR;
         end
         default: state_d = S_IDLE;
      endcase

      // Idle-cycle watchdog: a byte accepted on the expiring edge wins.
      if (loading(state_q)) begin
         if (accept) begin
            tmo_d = '0;
         end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_FIN_ERR;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      rdy_d = loading(state_d);
   end

   assign BYTE_READY = rdy_q;
   assign WR_EN      = wr_en_q;
   assign WR_ADDRESS = wr_addr_q;
   assign WR_DATA    = wr_data_q;
   assign CPU_HOLD   = loading(state_q);
   assign DONE       = (state_q == S_FIN_OK);
   assign ERROR      = (state_q == S_FIN_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Randomized + directed bench for instr_loader with a frame-level reference
// model: the model walks the byte list and per-byte gaps and predicts the
// written words, the number of bytes consumed and the final status.
module tb_instr_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          MAXW = 256;
   localparam int          TMO  = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        START;
   logic        BYTE_VALID;
   logic [7:0]  BYTE_DATA;
   logic        BYTE_READY;
   logic        WR_EN;
   logic [31:0] WR_ADDRESS;
   logic [31:0] WR_DATA;
   logic        CPU_HOLD;
   logic        DONE;
   logic        ERROR;

   instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .START(START), .BYTE_VALID(BYTE_VALID),
      .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY), .WR_EN(WR_EN),
      .WR_ADDRESS(WR_ADDRESS), .WR_DATA(WR_DATA), .CPU_HOLD(CPU_HOLD),
      .DONE(DONE), .ERROR(ERROR)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [7:0]  fb[$];      // frame bytes
   int          fg[$];      // idle cycles before each byte
   logic [63:0] exp_wr[$];
   logic [63:0] obs_wr[$];
   bit          exp_ok;
   int          exp_cons;
   int          cons;

   always @(negedge clk) if (WR_EN) obs_wr.push_back({WR_ADDRESS, WR_DATA});

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pushb(input logic [7:0] b);
      fb.push_back(b);
      fg.push_back(0);
   endtask

   // Reference: interpret the frame from its rules.
   task automatic model();
      int n;
      logic [7:0] x;
      exp_wr.delete();
      exp_ok = 1'b0; exp_cons = 0; n = 0; x = 8'h00;
      for (int i = 0; i < fb.size(); i++) begin
         if (fg[i] >= TMO) break;                  // loader gave up before this byte
         exp_cons++;
         if (i == 1) begin
            n = int'({fb[0], fb[1]});
            if (n > MAXW) break;
         end else if (i >= 2 && i < 2 + 4 * n) begin
            x ^= fb[i];
            if ((i - 2) % 4 == 3)
               exp_wr.push_back({BASE + 32'(4 * ((i - 2) / 4)),
                                 fb[i-3], fb[i-2], fb[i-1], fb[i]});
         end else if (i == 2 + 4 * n) begin
            exp_ok = (fb[i] == x);
            break;
         end
      end
   endtask

   task automatic drive(input int stop_after, input int mid_start);
      cons  = 0;
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
      chk("start_hold", 64'(CPU_HOLD), 64'(1));
      chk("start_rdy",  64'(BYTE_READY), 64'(1));
      chk("start_done", 64'(DONE), 64'(0));
      chk("start_err",  64'(ERROR), 64'(0));
      for (int i = 0; i < fb.size() && i < stop_after; i++) begin
         BYTE_VALID = 1'b0;
         repeat (fg[i]) @(negedge clk);
         if (!BYTE_READY) break;
         BYTE_VALID = 1'b1;
         BYTE_DATA  = fb[i];
         START      = (i == mid_start);
         @(negedge clk);
         cons++;
         START = 1'b0;
      end
      BYTE_VALID = 1'b0;
   endtask

   task automatic run_frame(input int mid_start);
      model();
      obs_wr.delete();
      drive(1 << 30, mid_start);
      chk("consumed", 64'(cons), 64'(exp_cons));
      chk("done",  64'(DONE), 64'(exp_ok));
      chk("error", 64'(ERROR), 64'(!exp_ok));
      chk("hold_end", 64'(CPU_HOLD), 64'(0));
      chk("rdy_end", 64'(BYTE_READY), 64'(0));
      repeat (2) @(negedge clk);
      #1;
      chk("wr_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
      for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++)
         chk($sformatf("wr%0d", k), obs_wr[k], exp_wr[k]);
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_rdy"},   64'(BYTE_READY), 64'(0));
      chk({p, "_wren"},  64'(WR_EN), 64'(0));
      chk({p, "_waddr"}, 64'(WR_ADDRESS), 64'(BASE));
      chk({p, "_wdata"}, 64'(WR_DATA), 64'(0));
      chk({p, "_hold"},  64'(CPU_HOLD), 64'(0));
      chk({p, "_done"},  64'(DONE), 64'(0));
      chk({p, "_err"},   64'(ERROR), 64'(0));
   endtask

   // 2-word image 0x2008_0005, 0xAC01_0004; its true checksum is 0x84.
   task automatic nominal(input logic [7:0] c);
      fb.delete(); fg.delete();
      pushb(8'h00); pushb(8'h02);
      pushb(8'h20); pushb(8'h08); pushb(8'h00); pushb(8'h05);
      pushb(8'hAC); pushb(8'h01); pushb(8'h00); pushb(8'h04);
      pushb(c);
   endtask

   task automatic rand_frame();
      int n;
      logic [7:0] x, b;
      fb.delete(); fg.delete();
      x = 8'h00;
      case ($urandom_range(0, 9))
         0:       n = 0;
         1:       n = int'($urandom_range(257, 600));
         default: n = int'($urandom_range(1, 6));
      endcase
      pushb(n[15:8]); pushb(n[7:0]);
      if (n > MAXW) begin
         pushb(8'($urandom)); pushb(8'($urandom));
      end else begin
         for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            x ^= b;
            pushb(b);
         end
         if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
         pushb(x);
      end
      for (int i = 0; i < fg.size(); i++)
         if ($urandom_range(0, 7) == 0) fg[i] = int'($urandom_range(1, TMO));
   endtask

   initial begin
      rst = 1'b1; START = 1'b0; BYTE_VALID = 1'b0; BYTE_DATA = 8'h00;
      #1;
      chk_reset_vals("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      nominal(8'h84); run_frame(-1);          // good image
      nominal(8'h80); run_frame(-1);          // bad checksum, writes kept
      nominal(8'h81); run_frame(-1);
      fb.delete(); fg.delete();               // oversize header, extra bytes refused
      pushb(8'h01); pushb(8'h01); pushb(8'h11); pushb(8'h22);
      run_frame(-1);
      fb.delete(); fg.delete();               // zero length
      pushb(8'h00); pushb(8'h00); pushb(8'h00);
      run_frame(-1);
      nominal(8'h84); fg[5] = TMO;     run_frame(-1);   // stall after 3rd data byte
      nominal(8'h84); fg[5] = TMO - 1; run_frame(-1);   // longest tolerated gap
      nominal(8'h84); run_frame(4);                     // START mid-frame ignored

      // reset while the second word's write strobe is active
      nominal(8'h84);
      obs_wr.delete();
      drive(10, -1);
      chk("pre_rst_wren", 64'(WR_EN), 64'(1));
      rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      nominal(8'h84); run_frame(-1);

      for (int r = 0; r < 30; r++) begin
         rand_frame();
         run_frame(int'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
